// File: rtl/rst_pkg.sv
// Shared types and constants for the RST ciphertext serializer.
package rst_pkg;

  typedef logic [7:0]  rst_char_t;
  typedef logic [15:0] rst_pair_t;

  // Output FSM: EMPTY = nothing to send, HI/LO = which byte of pair_q is on out_char.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2
  } ser_state_e;

  localparam rst_char_t NUL_CHAR = 8'h00;

endpackage

// File: rtl/rst_pair_fifo.sv
// Synchronous FIFO of 16-bit ciphertext pairs with first-word-fall-through read.
// The caller only asserts push when there is room (or a pop at the same edge)
// and only asserts pop when the FIFO is non-empty.
module rst_pair_fifo
  import rst_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  rst_pair_t     wdata,
  output rst_pair_t     rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  rst_pair_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level_q;

  // Storage write.
  // NOTE: the data array has no reset; pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign level = level_q;
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/rst_ctxt_serializer.sv
// Buffers 16-bit ciphertext pairs from the RST cipher and streams them out as
// bytes, high byte first, over a valid/ready handshake. Pairs arriving with no
// room are dropped and latched in err_overflow.
// Optional build macro: RST_SER_BYPASS_EN - an empty FIFO lets an incoming pair
// load the output register directly, giving one-edge latency.
module rst_ctxt_serializer
  import rst_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   ctxt_str,
  input  logic          ctxt_ready,
  output logic [7:0]    out_char,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          full,
  output logic [LW-1:0] level,
  output logic          err_overflow
);

  ser_state_e state_q, state_d;
  rst_pair_t  pair_q, pair_d;
  logic       err_q;

  rst_pair_t  fifo_rdata;
  logic       fifo_full, fifo_empty;
  logic       fifo_push, fifo_pop;
  logic       would_pop, bypass, push_req, drop;

  rst_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (ctxt_str),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Push/pop arbitration: a full FIFO still accepts a pair when a pop frees a slot.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    would_pop = (state_q == EMPTY) || ((state_q == LO) && out_ready);
    fifo_pop  = would_pop && !fifo_empty;
`ifdef RST_SER_BYPASS_EN
    bypass    = would_pop && fifo_empty && ctxt_ready;
`else
    bypass    = 1'b0;
`endif
    push_req  = ctxt_ready && !bypass;
    fifo_push = push_req && (!fifo_full || fifo_pop);
    drop      = push_req && !fifo_push;
  end

  // Output FSM next state, output register load and byte selection.
  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    out_valid = 1'b0;
    out_char  = NUL_CHAR;
    case (state_q)
      EMPTY: begin
        if (fifo_pop) begin
          pair_d  = fifo_rdata;
          state_d = HI;
        end else if (bypass) begin
          pair_d  = ctxt_str;
          state_d = HI;
        end
      end
      HI: begin
        out_valid = 1'b1;
        out_char  = pair_q[15:8];
        if (out_ready) state_d = LO;
      end
      LO: begin
        out_valid = 1'b1;
        out_char  = pair_q[7:0];
        if (out_ready) begin
          if (fifo_pop) begin
            pair_d  = fifo_rdata;
            state_d = HI;
          end else if (bypass) begin
            pair_d  = ctxt_str;
            state_d = HI;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, output register and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      pair_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      if (drop) err_q <= 1'b1;
    end
  end

  assign full         = fifo_full;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_rst_ctxt_serializer.sv
// Self-checking bench for rst_ctxt_serializer: directed scenarios plus random
// traffic, all compared against a queue-based model of the serializer.
module tb_rst_ctxt_serializer;

  localparam int DEPTH = 4;
`ifdef RST_SER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] ctxt_str;
  logic        ctxt_ready;
  logic [7:0]  out_char;
  logic        out_valid;
  logic        out_ready;
  logic        full;
  logic [2:0]  level;
  logic        err_overflow;

  rst_ctxt_serializer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctxt_str     (ctxt_str),
    .ctxt_ready   (ctxt_ready),
    .out_char     (out_char),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .full         (full),
    .level        (level),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: queued pairs, the pair being sent, and how many of its bytes remain.
  logic [15:0] mq[$];
  logic [15:0] m_reg;
  int          m_left;
  bit          m_err;

  logic [7:0]  rx[$];
  bit          prev_stall;
  logic [7:0]  prev_char;
  logic        obs_valid;
  logic [7:0]  obs_char;
  logic [2:0]  obs_level;
  logic        obs_full;
  logic        obs_err;

  task automatic model_reset();
    mq.delete();
    m_reg      = '0;
    m_left     = 0;
    m_err      = 1'b0;
    prev_stall = 1'b0;
  endtask

  // One clock edge of the serializer, described as byte/pair bookkeeping.
  task automatic model_edge(input logic cr, input logic [15:0] str, input logic ordy);
    int bl;
    bit pop_now, byp, acc;
    bl = m_left;
    if (bl > 0 && ordy) bl--;
    pop_now = (bl == 0) && (mq.size() > 0);
    byp     = BYP && (bl == 0) && (mq.size() == 0) && cr;
    acc     = cr && !byp && ((mq.size() < DEPTH) || pop_now);
    if (pop_now) begin
      m_reg = mq.pop_front();
      bl    = 2;
    end
    if (byp) begin
      m_reg = str;
      bl    = 2;
    end
    if (acc) mq.push_back(str);
    else if (cr && !byp) m_err = 1'b1;
    m_left = bl;
  endtask

  task automatic compare_outputs();
    logic       exp_valid;
    logic [7:0] exp_char;
    exp_valid = (m_left > 0);
    exp_char  = (m_left == 2) ? m_reg[15:8] : m_reg[7:0];
    checks++;
    if (out_valid !== exp_valid) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_valid, $time);
    end
    if (exp_valid) begin
      checks++;
      if (out_char !== exp_char) begin
        errors++;
        $display("FAIL out_char: got %h expected %h at %0t", out_char, exp_char, $time);
      end
    end
    if (prev_stall) begin
      checks++;
      if (out_char !== prev_char) begin
        errors++;
        $display("FAIL stall_hold: got %h expected %h at %0t", out_char, prev_char, $time);
      end
    end
    checks++;
    if (level !== 3'(mq.size())) begin
      errors++;
      $display("FAIL level: got %0d expected %0d at %0t", level, mq.size(), $time);
    end
    checks++;
    if (full !== (mq.size() == DEPTH)) begin
      errors++;
      $display("FAIL full: got %b expected %b at %0t", full, (mq.size() == DEPTH), $time);
    end
    checks++;
    if (err_overflow !== m_err) begin
      errors++;
      $display("FAIL err_overflow: got %b expected %b at %0t", err_overflow, m_err, $time);
    end
  endtask

  // Drive one cycle: inputs and checks on the falling edge, model on the rising edge.
  task automatic step(input logic cr, input logic [15:0] str, input logic ordy);
    @(negedge clk);
    ctxt_ready = cr;
    ctxt_str   = str;
    out_ready  = ordy;
    compare_outputs();
    obs_valid  = out_valid;
    obs_char   = out_char;
    obs_level  = level;
    obs_full   = full;
    obs_err    = err_overflow;
    if (out_valid && ordy) rx.push_back(out_char);
    prev_stall = out_valid && !ordy;
    prev_char  = out_char;
    @(posedge clk);
    model_edge(cr, str, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    ctxt_ready = 1'b0;
    out_ready  = 1'b0;
    model_reset();
    rx.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic string rx_str();
    string s;
    s = "";
    foreach (rx[i]) s = $sformatf("%s%c", s, rx[i]);
    return s;
  endfunction

  task automatic check_rx(input string name, input string exp);
    checks++;
    if (rx_str() != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, rx_str(), exp);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_char !== 8'h00 || full !== 1'b0 ||
        level !== 3'd0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s: got valid=%b char=%h full=%b level=%0d err=%b expected all zero",
               name, out_valid, out_char, full, level, err_overflow);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    ctxt_ready = 1'b0;
    ctxt_str   = '0;
    out_ready  = 1'b0;
    model_reset();
    #12;
    check_reset_values("reset_values");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int          off;
    logic        ev;
    logic [7:0]  ec;
    off = BYP ? 0 : 1;
    step(1'b1, "KL", 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0000, 1'b1);
      ev = (i == off) || (i == off + 1);
      ec = (i == off) ? "K" : "L";
      checks++;
      if (obs_valid !== ev || (ev && obs_char !== ec)) begin
        errors++;
        $display("FAIL latency[%0d]: got valid=%b char=%h expected valid=%b char=%h",
                 i, obs_valid, obs_char, ev, ec);
      end
    end
    check_rx("latency_stream", "KL");
  endtask

  task automatic test_burst();
    logic [15:0] burst[5];
    burst = '{"KL", "GJ", "GJ", "ED", "EF"};
    rx.delete();
    foreach (burst[i]) step(1'b1, burst[i], 1'b1);
    repeat (12) step(1'b0, 16'h0000, 1'b1);
    check_rx("burst_stream", "KLGJGJEDEF");
    checks++;
    if (err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL burst_no_overflow: got %b expected 0", err_overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0);
    step(1'b1, 16'($urandom), 1'b0);
    checks++;
    if (obs_level !== 3'd4 || obs_full !== 1'b1 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_fill: got level=%0d full=%b err=%b expected 4 1 0",
               obs_level, obs_full, obs_err);
    end
    step(1'b0, 16'h0000, 1'b0);
    checks++;
    if (obs_level !== 3'd4 || obs_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drop: got level=%0d err=%b expected 4 1", obs_level, obs_err);
    end
    repeat (14) step(1'b0, 16'h0000, 1'b1);
    checks++;
    if (rx.size() != 10) begin
      errors++;
      $display("FAIL overflow_drain: got %0d bytes expected 10", rx.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1'b1, "AB", 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, logic'(i % 2));
    check_rx("backpressure_stream", "AB");
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b1, "PQ", 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    checks++;
    if (obs_level !== 3'd4 || obs_full !== 1'b1 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL full_pop: got level=%0d full=%b err=%b expected 4 1 0",
               obs_level, obs_full, obs_err);
    end
    repeat (14) step(1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    checks++;
    if (obs_level !== 3'd3 || obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: got level=%0d valid=%b expected 3 1", obs_level, obs_valid);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset_mid_async");
    model_reset();
    rx.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, "XY", 1'b1);
    repeat (5) step(1'b0, 16'h0000, 1'b1);
    check_rx("reset_mid_stream", "XY");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 2) != 0), 16'($urandom), logic'($urandom_range(0, 3) != 0));
    repeat (4 * DEPTH + 6) step(1'b0, 16'h0000, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL random_drained: got valid=%b level=%0d expected 0 0", out_valid, level);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_burst();
    test_overflow();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
